// File: rtl/pipe_share_arb_pkg.sv
// Shared constants and pipe-stage layout for the pipe_share_arb slice.
// The top re-derives the stage layout from its own parameters.
package pipe_share_pkg;
   localparam int DEF_WIDTH = 2;
   localparam int DEF_NREQ  = 4;
   localparam int MAX_NREQ  = 8;

   typedef struct packed {
      logic                        valid;
      logic [$clog2(DEF_NREQ)-1:0] id;
      logic [DEF_WIDTH-1:0]        data;
   } pipe_stage_t;
endpackage

// File: rtl/pipe_share_arb_if.sv
// Requester/response handshake bundle for pipe_share_arb.
// master = traffic source/sink side, slave = the arbiter itself.
interface pipe_share_arb_if import pipe_share_pkg::*; #(
   parameter int WIDTH = DEF_WIDTH,
   parameter int NREQ  = DEF_NREQ
);
   localparam int IDW = $clog2(NREQ);

   logic [NREQ-1:0]       req_valid;
   logic [NREQ*WIDTH-1:0] req_data;
   logic [NREQ-1:0]       req_ready;
   logic                  hold;
   logic                  rsp_valid;
   logic [WIDTH-1:0]      rsp_data;
   logic [IDW-1:0]        rsp_id;
   logic                  rsp_ready;
   logic                  busy;

   modport master (
      output req_valid, req_data, hold, rsp_ready,
      input  req_ready, rsp_valid, rsp_data, rsp_id, busy
   );

   modport slave (
      input  req_valid, req_data, hold, rsp_ready,
      output req_ready, rsp_valid, rsp_data, rsp_id, busy
   );
endinterface

// File: rtl/pipe_share_arb_rr.sv
// Round-robin one-hot grant: lowest requesting index at or after ptr, wrapping.
// Purely combinational, no backpressure of its own.
module rr_arbiter import pipe_share_pkg::*; #(
   parameter int NREQ = DEF_NREQ,
   localparam int IDW = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [IDW-1:0]  ptr,
   output logic [NREQ-1:0] grant
);
   logic [IDW-1:0] idx;

   // Scan from the farthest offset inward so the nearest requester wins last.
   always_comb begin
      grant = '0;
      idx   = '0;
      for (int off = NREQ - 1; off >= 0; off--) begin
         idx = IDW'((int'(ptr) + off) % NREQ);
         if (req[idx]) begin
            grant      = '0;
            grant[idx] = 1'b1;
         end
      end
   end
endmodule

// File: rtl/pipe_share_arb.sv
// Round-robin arbiter feeding a shared two-stage pipe; payload leaves unchanged.
// Latency 2 cycles; a stalled output freezes both stages and blocks all grants.
module pipe_share_arb import pipe_share_pkg::*; #(
   parameter int WIDTH = DEF_WIDTH,
   parameter int NREQ  = DEF_NREQ
) (
   input logic             clk,
   input logic             rst_n,
   pipe_share_arb_if.slave bus
);
   localparam int IDW = $clog2(NREQ);

   typedef struct packed {
      logic             valid;
      logic [IDW-1:0]   id;
      logic [WIDTH-1:0] data;
   } stage_t;

   stage_t           s1, s2, s1_nxt;
   logic [IDW-1:0]   rr_ptr, gnt_id, ptr_nxt;
   logic [NREQ-1:0]  grant, accept;
   logic [WIDTH-1:0] gnt_data;
   logic             advance, xfer;

   rr_arbiter #(.NREQ(NREQ)) u_rr (
      .req   (bus.req_valid),
      .ptr   (rr_ptr),
      .grant (grant)
   );

   // Gating with rst_n keeps requesters from seeing an accept the flops would drop.
   assign advance = !(s2.valid && !bus.rsp_ready);
   assign accept  = (rst_n && advance && !bus.hold) ? grant : '0;
   assign xfer    = |(bus.req_valid & accept);

   always_comb begin
      gnt_id   = '0;
      gnt_data = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (grant[i]) begin
            gnt_id   = IDW'(i);
            gnt_data = bus.req_data[i*WIDTH +: WIDTH];
         end
      end
   end

   always_comb begin
      s1_nxt  = '0;
      ptr_nxt = (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + 1'b1;
      if (xfer) begin
         s1_nxt.valid = 1'b1;
         s1_nxt.id    = gnt_id;
         s1_nxt.data  = ~gnt_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1     <= '0;
         s2     <= '0;
         rr_ptr <= '0;
      end else begin
         if (advance) begin
            s1       <= s1_nxt;
            s2.valid <= s1.valid;
            s2.id    <= s1.id;
            s2.data  <= ~s1.data;
         end
         if (xfer) begin
            rr_ptr <= ptr_nxt;
         end
      end
   end

   assign bus.req_ready = accept;
   assign bus.rsp_valid = s2.valid;
   assign bus.rsp_data  = s2.data;
   assign bus.rsp_id    = s2.id;
   assign bus.busy      = s1.valid || s2.valid;
endmodule

// File: tb/tb_pipe_share_arb.sv
// Directed bench for pipe_share_arb: per-cycle vectors with hand-computed grants and responses.
module tb_pipe_share_arb;
   import pipe_share_pkg::*;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   pipe_share_arb_if #(.WIDTH(2), .NREQ(4)) bus ();

   pipe_share_arb #(.WIDTH(2), .NREQ(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int total = 0;
   int bad   = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   typedef struct packed {
      logic [3:0] rv;
      logic       hold;
      logic       rr;
      logic [3:0] rdy;
      logic       vld;
      logic [1:0] id;
      logic       busy;
   } row_t;

   // req3=00 req2=01 req1=10 req0=11
   logic [7:0] tbl_data = 8'b00_01_10_11;

   localparam int NROWS = 32;
   row_t tbl [0:NROWS-1] = '{
      // all four requesting, fresh pointer
      '{4'hF, 1'b0, 1'b1, 4'b0001, 1'b0, 2'd0, 1'b0},
      '{4'hF, 1'b0, 1'b1, 4'b0010, 1'b0, 2'd0, 1'b1},
      '{4'hF, 1'b0, 1'b1, 4'b0100, 1'b1, 2'd0, 1'b1},
      '{4'hF, 1'b0, 1'b1, 4'b1000, 1'b1, 2'd1, 1'b1},
      '{4'hF, 1'b0, 1'b1, 4'b0001, 1'b1, 2'd2, 1'b1},
      '{4'h0, 1'b0, 1'b1, 4'b0000, 1'b1, 2'd3, 1'b1},
      '{4'h0, 1'b0, 1'b1, 4'b0000, 1'b1, 2'd0, 1'b1},
      '{4'h0, 1'b0, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0},
      // downstream stall for three cycles
      '{4'hF, 1'b0, 1'b1, 4'b0010, 1'b0, 2'd0, 1'b0},
      '{4'hF, 1'b0, 1'b1, 4'b0100, 1'b0, 2'd0, 1'b1},
      '{4'hF, 1'b0, 1'b0, 4'b0000, 1'b1, 2'd1, 1'b1},
      '{4'hF, 1'b0, 1'b0, 4'b0000, 1'b1, 2'd1, 1'b1},
      '{4'hF, 1'b0, 1'b0, 4'b0000, 1'b1, 2'd1, 1'b1},
      '{4'hF, 1'b0, 1'b1, 4'b1000, 1'b1, 2'd1, 1'b1},
      '{4'hF, 1'b0, 1'b1, 4'b0001, 1'b1, 2'd2, 1'b1},
      '{4'h0, 1'b0, 1'b1, 4'b0000, 1'b1, 2'd3, 1'b1},
      '{4'h0, 1'b0, 1'b1, 4'b0000, 1'b1, 2'd0, 1'b1},
      '{4'h0, 1'b0, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0},
      // hold blocks grants, pipe drains, resumes at pointer
      '{4'hF, 1'b0, 1'b1, 4'b0010, 1'b0, 2'd0, 1'b0},
      '{4'hF, 1'b1, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b1},
      '{4'hF, 1'b1, 1'b1, 4'b0000, 1'b1, 2'd1, 1'b1},
      '{4'hF, 1'b1, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0},
      '{4'hF, 1'b0, 1'b1, 4'b0100, 1'b0, 2'd0, 1'b0},
      '{4'h0, 1'b0, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b1},
      '{4'h0, 1'b0, 1'b1, 4'b0000, 1'b1, 2'd2, 1'b1},
      '{4'h0, 1'b0, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0},
      // sparse requesters 1 and 3, pointer moved to 2 first
      '{4'b0010, 1'b0, 1'b1, 4'b0010, 1'b0, 2'd0, 1'b0},
      '{4'b1010, 1'b0, 1'b1, 4'b1000, 1'b0, 2'd0, 1'b1},
      '{4'b1010, 1'b0, 1'b1, 4'b0010, 1'b1, 2'd1, 1'b1},
      '{4'b0000, 1'b0, 1'b1, 4'b0000, 1'b1, 2'd3, 1'b1},
      '{4'b0000, 1'b0, 1'b1, 4'b0000, 1'b1, 2'd1, 1'b1},
      '{4'b0000, 1'b0, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0}
   };

   function automatic logic [1:0] pay(input logic [1:0] id);
      return tbl_data[id*2 +: 2];
   endfunction

   initial begin
      bus.req_valid = 4'hF;
      bus.req_data  = 8'h00;
      bus.hold      = 1'b0;
      bus.rsp_ready = 1'b1;

      // reset state, with requests present
      @(negedge clk);
      #1;
      chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      chk("rst_rsp_data",  32'(bus.rsp_data),  32'd0);
      chk("rst_rsp_id",    32'(bus.rsp_id),    32'd0);
      chk("rst_busy",      32'(bus.busy),      32'd0);
      chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
      @(negedge clk);
      rst_n         = 1'b1;
      bus.req_valid = 4'h0;

      // single transfer from requester 0
      bus.req_data  = 8'b00_00_00_10;
      bus.req_valid = 4'b0001;
      #1;
      chk("one_ready", 32'(bus.req_ready), 32'b0001);
      chk("one_vld0",  32'(bus.rsp_valid), 32'd0);
      @(negedge clk);
      bus.req_valid = 4'b0000;
      #1;
      chk("one_vld1",  32'(bus.rsp_valid), 32'd0);
      chk("one_busy1", 32'(bus.busy),      32'd1);
      @(negedge clk);
      #1;
      chk("one_vld2",  32'(bus.rsp_valid), 32'd1);
      chk("one_data",  32'(bus.rsp_data),  32'b10);
      chk("one_id",    32'(bus.rsp_id),    32'd0);
      @(negedge clk);
      #1;
      chk("one_vld3",  32'(bus.rsp_valid), 32'd0);
      chk("one_busy3", 32'(bus.busy),      32'd0);

      rst_n = 1'b0;
      @(negedge clk);
      rst_n        = 1'b1;
      bus.req_data = tbl_data;

      for (int n = 0; n < NROWS; n++) begin
         bus.req_valid = tbl[n].rv;
         bus.hold      = tbl[n].hold;
         bus.rsp_ready = tbl[n].rr;
         #1;
         chk($sformatf("row%0d_ready", n), 32'(bus.req_ready), 32'(tbl[n].rdy));
         chk($sformatf("row%0d_busy", n),  32'(bus.busy),      32'(tbl[n].busy));
         chk($sformatf("row%0d_vld", n),   32'(bus.rsp_valid), 32'(tbl[n].vld));
         if (tbl[n].vld) begin
            chk($sformatf("row%0d_id", n),   32'(bus.rsp_id),   32'(tbl[n].id));
            chk($sformatf("row%0d_data", n), 32'(bus.rsp_data), 32'(pay(tbl[n].id)));
         end
         @(negedge clk);
      end

      // fill both stages then reset mid-flight
      bus.req_valid = 4'hF;
      #1;
      chk("mid_ready0", 32'(bus.req_ready), 32'b0100);
      @(negedge clk);
      #1;
      chk("mid_ready1", 32'(bus.req_ready), 32'b1000);
      @(negedge clk);
      bus.req_valid = 4'h0;
      #1;
      chk("mid_full_vld", 32'(bus.rsp_valid), 32'd1);
      chk("mid_full_id",  32'(bus.rsp_id),    32'd2);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_vld",  32'(bus.rsp_valid), 32'd0);
      chk("mid_rst_busy", 32'(bus.busy),      32'd0);
      chk("mid_rst_id",   32'(bus.rsp_id),    32'd0);
      chk("mid_rst_data", 32'(bus.rsp_data),  32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 3; c++) begin
         #1;
         chk($sformatf("post_rst%0d_vld", c), 32'(bus.rsp_valid), 32'd0);
         chk($sformatf("post_rst%0d_busy", c), 32'(bus.busy),     32'd0);
         @(negedge clk);
      end
      bus.req_valid = 4'hF;
      #1;
      chk("post_rst_grant", 32'(bus.req_ready), 32'b0001);
      @(negedge clk);
      bus.req_valid = 4'h0;
      @(negedge clk);
      #1;
      chk("post_rst_rsp_vld",  32'(bus.rsp_valid), 32'd1);
      chk("post_rst_rsp_id",   32'(bus.rsp_id),    32'd0);
      chk("post_rst_rsp_data", 32'(bus.rsp_data),  32'(pay(2'd0)));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/pipe_share_arb.md
PIPE_SHARE_ARB -- requirements
Module: pipe_share_arb

Interface
REQ-001 Parameter WIDTH, default 2, data width of each requester payload and of the response.
REQ-002 Parameter NREQ, default 4, number of requesters; legal range 2..8.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset, with ports named clk and rst_n.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 req_valid  input  NREQ  per-requester request valid.
REQ-007 req_data  input  NREQ*WIDTH  packed payloads; requester i occupies bits [i*WIDTH +: WIDTH].
REQ-008 req_ready  output  NREQ  per-requester accept; at most one bit high per cycle.
REQ-009 hold  input  1  when high, no new request is granted; the pipe keeps draining.
REQ-010 rsp_valid  output  1  stage-2 result valid.
REQ-011 rsp_data  output  WIDTH  result payload, equal to ~~req_data of the granted requester, i.e. unchanged.
REQ-012 rsp_id  output  $clog2(NREQ)  index of the requester that issued the result.
REQ-013 rsp_ready  input  1  downstream accept.
REQ-014 busy  output  1  high when either pipeline stage holds a valid entry.

Function
REQ-015 The shared datapath SHALL be two registered stages: stage1 captures ~payload, and stage2 captures ~stage1; each stage carries a valid bit and an id.
REQ-016 advance = !(s2_valid && !rsp_ready); both stages SHALL load only when advance is high, and SHALL otherwise hold value and valid.
REQ-017 Arbitration is round-robin: the grant goes to the lowest index at or after rr_ptr, with wrap past NREQ-1 to 0, among requesters with req_valid high.
REQ-018 req_ready[i] = advance && !hold && grant[i]; this is a combinational path from rsp_ready, which is permitted.
REQ-019 A transfer occurs when req_valid[i] && req_ready[i]; on a transfer, rr_ptr <= (i+1) mod NREQ; otherwise rr_ptr holds.
REQ-020 When advance is high and there is no transfer, stage1 SHALL load valid=0; bubbles propagate and are not collapsed.
REQ-021 Latency: a transfer at edge k appears on rsp_valid/rsp_data/rsp_id after edge k+2, provided rsp_ready is high at edges k+1 and k+2 where required.
REQ-022 Throughput SHALL be one transfer per cycle while rsp_ready stays high.
REQ-023 Stalled output: rsp_valid, rsp_data and rsp_id SHALL remain stable until rsp_ready is sampled high.
REQ-024 rsp_valid falling edge: the entry leaves on an edge where rsp_valid && rsp_ready, and stage2 takes stage1's contents, which may be a bubble.
REQ-025 A requester that lowers req_valid without a transfer SHALL forfeit nothing; rr_ptr does not move.
REQ-026 hold asserted mid-stream SHALL block new grants from the next evaluation; entries already in flight complete normally.
REQ-027 busy = s1_valid || s2_valid.

Reset
REQ-028 On rst_n low, asynchronously: rr_ptr=0, s1_valid=s2_valid=0, stage data=0, stage ids=0; hence rsp_valid=0, rsp_data=0, rsp_id=0, busy=0, req_ready=0.
REQ-029 Reset asserted mid-operation SHALL discard all in-flight entries; no response is produced for them after release.
REQ-030 The first grant after reset release SHALL favour requester 0.

Structure
REQ-031 Package pipe_share_pkg SHALL hold the default WIDTH/NREQ constants and the pipe-stage struct (valid, id, data).
REQ-032 Round-robin grant logic SHALL be a sub-module rr_arbiter (inputs: req, ptr; output: one-hot grant); pipeline and pointer state stay in pipe_share_arb.

Verification
REQ-033 Reset then req_valid=4'b0001, data0=2'b10, rsp_ready=1 -> rsp_valid high 2 cycles after transfer, rsp_data=2'b10, rsp_id=0.
REQ-034 All four requesters valid continuously, rsp_ready=1 -> grants in order 0,1,2,3,0; rsp_id follows the same order back-to-back, with no bubbles.
REQ-035 Stream with rsp_ready=0 for 3 cycles -> rsp_* stable; req_ready=0 while stalled; after release, no loss and no duplication.
REQ-036 hold=1 with requests pending -> no req_ready; busy falls within 2 cycles; hold=0 -> grant resumes at rr_ptr.
REQ-037 rst_n pulsed low with both stages valid -> rsp_valid=0 immediately, busy=0, no stale response after release, first grant goes to requester 0.
REQ-038 Only requesters 1 and 3 valid, with rr_ptr=2 -> requester 3 is granted first, then 1 after the wrap.
